move_engine: RTL

//  Clocked, parametrised 2048 move engine for an N x N board of W-bit exponent tiles.
//  One start request applies one slide+merge in the requested direction, processing one line per cycle.
//  If the board changed, it spawns one new tile at an LFSR-chosen empty cell, then reports the move flag,

---
 rtl/move_engine.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/move_engine.sv
// rtl/move_engine.sv - 2048 slide/merge engine, one line per clock, LFSR tile spawn
// Lines are read from the destination edge inward, so every direction shares one slide/merge datapath.
module move_engine #(
  parameter int          N       = 4,
  parameter int          W       = 4,
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      dir,
  input  logic [N*N*W-1:0]                board_in,
  output logic                            busy,
  output logic                            done,
  output logic [N*N*W-1:0]                board_out,
  output logic                            moved,
  output logic [$clog2(N*N/2+1)-1:0]      merge_cnt,
  output logic                            win,
  output logic                            stuck
);

  localparam int CELLS = N * N;
  localparam int BW    = CELLS * W;
  localparam int MW    = $clog2(CELLS / 2 + 1);
  localparam int IW    = $clog2(N);
  localparam int SW    = $clog2(CELLS);
  localparam int KW    = $clog2(N + 1);
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_SPAWN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   spawn_q, spawn_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   board_q, board_d;
  logic            moved_q, moved_d;
  logic [MW-1:0]   merge_q, merge_d;
  logic            win_q, win_d;
  logic            stuck_q, stuck_d;
  logic            done_q, done_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic [W-1:0]    lin  [N];
  logic [W-1:0]    cmp  [N+1];
  logic [W-1:0]    lout [N+1];
  logic [KW-1:0]   k, j;
  logic            skip;
  logic [MW-1:0]   line_merges;
  logic            line_win;
  logic            line_changed;
  logic            stuck_calc;

  // Position p of a line, counted from the edge the tiles slide toward.
  function automatic int cell_of(input logic [1:0] d, input int ln, input int p);
    case (d)
      2'd0:    return ln * N + (N - 1 - p);
      2'd1:    return ln * N + p;
      2'd2:    return p * N + ln;
      default: return (N - 1 - p) * N + ln;
    endcase
  endfunction

  always_comb begin
    k            = '0;
    j            = '0;
    skip         = 1'b0;
    line_merges  = '0;
    line_win     = 1'b0;
    line_changed = 1'b0;
    for (int p = 0; p <= N; p++) begin
      cmp[p]  = '0;
      lout[p] = '0;
    end
    for (int p = 0; p < N; p++) begin
      lin[p] = work_q[cell_of(dir_q, int'(idx_q), p)*W +: W];
    end
    for (int p = 0; p < N; p++) begin
      if (lin[p] != '0) begin
        cmp[k] = lin[p];
        k      = k + 1'b1;
      end
    end
    // cmp[N] stays zero so the pair test never looks past the line end.
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != '0) begin
        if (cmp[i] == cmp[i+1] && cmp[i] != MAXV) begin
          lout[j]     = cmp[i] + 1'b1;
          line_merges = line_merges + 1'b1;
          if (cmp[i] + 1'b1 == W'(WIN_EXP)) line_win = 1'b1;
          skip        = 1'b1;
        end else begin
          lout[j] = cmp[i];
        end
        j = j + 1'b1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (lout[p] != lin[p]) line_changed = 1'b1;
    end
  end

  always_comb begin
    stuck_calc = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (work_q[(r*N+c)*W +: W] == '0) stuck_calc = 1'b0;
        if (c < N - 1 && work_q[(r*N+c)*W +: W] == work_q[(r*N+c+1)*W +: W]) stuck_calc = 1'b0;
        if (r < N - 1 && work_q[(r*N+c)*W +: W] == work_q[((r+1)*N+c)*W +: W]) stuck_calc = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    spawn_d = spawn_q;
    work_d  = work_q;
    board_d = board_q;
    moved_d = moved_q;
    merge_d = merge_q;
    win_d   = win_q;
    stuck_d = stuck_q;
    done_d  = 1'b0;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          work_d  = board_in;
          dir_d   = dir;
          idx_d   = '0;
          moved_d = 1'b0;
          merge_d = '0;
          win_d   = 1'b0;
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        for (int p = 0; p < N; p++) begin
          work_d[cell_of(dir_q, int'(idx_q), p)*W +: W] = lout[p];
        end
        moved_d = moved_q | line_changed;
        merge_d = merge_q + line_merges;
        win_d   = win_q | line_win;
        if (idx_q == IW'(N - 1)) begin
          spawn_d = SW'(lfsr_q[5:0] % CELLS);
          state_d = moved_d ? S_SPAWN : S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SPAWN: begin
        if (work_q[spawn_q*W +: W] == '0) begin
          work_d[spawn_q*W +: W] = W'(1);
          state_d = S_DONE;
        end else begin
          spawn_d = (spawn_q == SW'(CELLS - 1)) ? '0 : spawn_q + 1'b1;
        end
      end
      default: begin
        board_d = work_q;
        stuck_d = stuck_calc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      idx_q   <= '0;
      spawn_q <= '0;
      work_q  <= '0;
      board_q <= '0;
      moved_q <= 1'b0;
      merge_q <= '0;
      win_q   <= 1'b0;
      stuck_q <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      spawn_q <= spawn_d;
      work_q  <= work_d;
      board_q <= board_d;
      moved_q <= moved_d;
      merge_q <= merge_d;
      win_q   <= win_d;
      stuck_q <= stuck_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign busy      = (state_q != S_IDLE) || done_q;
  assign done      = done_q;
  assign board_out = board_q;
  assign moved     = moved_q;
  assign merge_cnt = merge_q;
  assign win       = win_q;
  assign stuck     = stuck_q;

endmodule
